svc_rv_div: RTL
===============

# svc_rv_div

Iterative radix-2 divider for the RV32M DIV/DIVU/REM/REMU instructions, living in the EX stage beside the ALU. It accepts one operation at a time and drives `op_active`. That signal feeds the hazard unit's `op_active_ex` input, which freezes PC, IF/ID, ID/EX, EX/MEM and MEM/WB until the result is ready. The result is presented for exactly one cycle, during which the EX/MEM register captures it.

## Interface
- `XLEN`, 32: operand/result width; must be a power of two ≥ 8; counter width is `$clog2(XLEN)`.

- `clk` input 1: sole clock; all state updates on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: valid divide op in EX; held high by the stalled pipeline for the whole operation.
- `kill` input 1: abort the current operation (trap/redirect); wins over `start`.
- `op` input 2: funct3[1:0]; 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `dividend` input XLEN: rs1 value; sampled only on acceptance.
- `divisor` input XLEN: rs2 value; sampled only on acceptance.
- `op_active` output 1: operation in progress; feeds hazard `op_active_ex`.
- `result_valid` output 1: one-cycle pulse; `result` is valid.
- `result` output XLEN: quotient or remainder, per the latched `op`.

## Operation
- States: IDLE, CALC, DONE.
- **IDLE**
  - `start && !kill` accepts the operation.
  - On acceptance, latch `op`, |dividend|, |divisor|, quotient-negate flag and remainder-negate flag.
  - Negation applies only for signed ops. The quotient is negated when the operand signs differ. The remainder is negated when the dividend is negative.
  - On acceptance with no special case: go to CALC with count = XLEN−1.
- **Special cases** (detected at acceptance; go to DONE directly, skipping CALC)
  - Divisor == 0: quotient = all ones; remainder = dividend (unsigned and signed).
  - Signed DIV/REM with dividend = 0x8000_0000 and divisor = −1 (XLEN-scaled): quotient = dividend; remainder = 0.
- **CALC**
  - One restoring step per cycle: shift {rem, quo} left by 1, trial-subtract the divisor, and set the quotient LSB if the result is non-negative.
  - Remainder register is XLEN+1 bits.
  - Count decrements each step; at count == 0 go to DONE.
- **DONE**
  - Result is the sign-fixed quotient (op[1]=0) or remainder (op[1]=1), computed combinationally from the registered values.
  - `result_valid` = 1.
  - Go to IDLE unconditionally. `start`, still high this cycle, is ignored.
- **`kill`**
  - In CALC or DONE: go to IDLE next cycle; no `result_valid`; latched state discarded.
  - In IDLE: blocks acceptance.
- **`op_active`**
  - Combinational: `(state==IDLE && start && !kill) || state==CALC`.
  - Low in DONE, so the pipeline advances and captures `result`.
- **Reset values**
  - state IDLE; `result_valid` 0; `result` 0; all latched registers 0.
  - `op_active` = 0 whenever `start` = 0.
- **Reset mid-operation:** immediate return to IDLE; no `result_valid`.

## Timing
- Acceptance at cycle T (`op_active` already high in T).
- Normal path:
  - CALC cycles T+1..T+XLEN.
  - DONE at T+XLEN+1, i.e. T+33 for XLEN=32.
  - `result_valid` high only in T+33.
- Special-case path: DONE at T+1.
- Back-to-back: a new `start` is accepted no earlier than the cycle after DONE.
- Register-output to `op_active` path is one comparator deep.

## Configuration
- `SVC_RV_DIV_REUSE_EN` defined:
  - Store the last normal-path operands (raw dividend, divisor, signedness `!op[0]`) together with the final quotient and remainder; a valid bit marks them usable.
  - The valid bit is set on each normal-path DONE. It is cleared by reset, by `kill`, and at the next normal-path acceptance.
  - An accepted op matching the stored operands and signedness goes to DONE at T+1 and selects the quotient or remainder per `op`. This covers the DIV-then-REM idiom.
- `SVC_RV_DIV_REUSE_EN` undefined: no operand cache; every non-special op takes XLEN+1 cycles.

## Test plan
- DIV 100 / 7, start at T → `op_active` 1 through T+32, `result_valid` at T+33, `result` = 14. Repeat with REM → 2.
- Signed: DIV −7 / 2 → 0xFFFF_FFFD (−3); REM −7 / 2 → 0xFFFF_FFFF (−1); REMU 0xFFFF_FFF9 / 2 → 1.
- DIVU 5 / 0 → 0xFFFF_FFFF at T+1; REM 5 / 0 → 5 at T+1; DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000; REM of the same operands → 0.
- Start DIVU 1000 / 3, assert `kill` at T+10 → IDLE at T+11, `op_active` 0 at T+11 (`start` low), no `result_valid`. A new DIVU 9 / 3 then yields 3 after 33 cycles.
- `rst_n` low at T+5 → `result_valid` 0, `result` 0, `op_active` 0 (`start` low); no spurious pulse after release.
- DIV 1234 / 10 then REM 1234 / 10 back-to-back → second `result_valid` at T'+1 with `result` = 4 when `SVC_RV_DIV_REUSE_EN` is defined, T'+33 when undefined. The first result is 123 at T+33 in both configurations.

Source files
------------

// File: rtl/svc_rv_div.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU in EX.
// Optional operand/result reuse cache: define SVC_RV_DIV_REUSE_EN.
module svc_rv_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            kill,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            op_active,
  output logic            result_valid,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   rem;
  logic [XLEN-1:0] quo;
  logic [XLEN-1:0] dvs;
  logic [1:0]      op_q;
  logic            neg_q;
  logic            neg_r;

  logic            sgn;
  logic            dvd_neg;
  logic            dvs_neg;
  logic [XLEN-1:0] dvd_abs;
  logic [XLEN-1:0] dvs_abs;
  logic            div_zero;
  logic            ovf;
  logic            accept;
  logic            hit;
  logic [XLEN+1:0] rem_sh;
  logic [XLEN+1:0] diff;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;

  assign sgn      = ~op[0];
  assign dvd_neg  = sgn & dividend[XLEN-1];
  assign dvs_neg  = sgn & divisor[XLEN-1];
  assign dvd_abs  = dvd_neg ? -dividend : dividend;
  assign dvs_abs  = dvs_neg ? -divisor : divisor;
  assign div_zero = (divisor == '0);
  assign ovf      = sgn
                  && (dividend == {1'b1, {(XLEN-1){1'b0}}})
                  && (divisor == '1);
  assign accept   = (state == S_IDLE) && start && !kill;

  // MSB of the XLEN+2 difference is the borrow of the trial subtract
  assign rem_sh = {rem, quo[XLEN-1]};
  assign diff   = rem_sh - {2'b00, dvs};

  assign q_fix = neg_q ? -quo : quo;
  assign r_fix = neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];

  assign op_active    = accept || (state == S_CALC);
  assign result_valid = (state == S_DONE) && !kill;
  assign result       = (state == S_DONE)
                      ? (op_q[1] ? r_fix : q_fix)
                      : '0;

`ifdef SVC_RV_DIV_REUSE_EN
  logic            c_vld;
  logic            c_sgn;
  logic            norm_q;
  logic [XLEN-1:0] c_dvd;
  logic [XLEN-1:0] c_dvs;
  logic [XLEN-1:0] c_quo;
  logic [XLEN-1:0] c_rem;

  assign hit = c_vld
            && (dividend == c_dvd)
            && (divisor == c_dvs)
            && (c_sgn == sgn);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_vld  <= 1'b0;
      c_sgn  <= 1'b0;
      norm_q <= 1'b0;
      c_dvd  <= '0;
      c_dvs  <= '0;
      c_quo  <= '0;
      c_rem  <= '0;
    end else if (kill) begin
      c_vld  <= 1'b0;
      norm_q <= 1'b0;
    end else if (accept && !div_zero && !ovf && !hit) begin
      c_vld  <= 1'b0;
      norm_q <= 1'b1;
      c_dvd  <= dividend;
      c_dvs  <= divisor;
      c_sgn  <= sgn;
    end else if (accept) begin
      norm_q <= 1'b0;
    end else if (state == S_DONE && norm_q) begin
      c_vld  <= 1'b1;
      norm_q <= 1'b0;
      c_quo  <= q_fix;
      c_rem  <= r_fix;
    end
  end
`else
  assign hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (kill) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_q <= op;
            if (div_zero) begin
              quo   <= '1;
              rem   <= {1'b0, dividend};
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= S_DONE;
            end else if (ovf) begin
              quo   <= dividend;
              rem   <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= S_DONE;
            end else if (hit) begin
`ifdef SVC_RV_DIV_REUSE_EN
              quo   <= c_quo;
              rem   <= {1'b0, c_rem};
`endif
              neg_q <= 1'b0;
              neg_r <= 1'b0;
              state <= S_DONE;
            end else begin
              quo   <= dvd_abs;
              rem   <= '0;
              dvs   <= dvs_abs;
              neg_q <= dvd_neg ^ dvs_neg;
              neg_r <= dvd_neg;
              cnt   <= CW'(XLEN-1);
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          quo <= {quo[XLEN-2:0], ~diff[XLEN+1]};
          rem <= diff[XLEN+1] ? rem_sh[XLEN:0] : diff[XLEN:0];
          cnt <= cnt - 1'b1;
          if (cnt == '0)
            state <= S_DONE;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
